// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode/control stage and the datapath.
// Holds opcode/funct encodings, ALU operation codes (shared with the alu),
// FSM state encoding and the instruction-class enum.
package cpu_pkg;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;  // LD / SD width

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // selects SUB

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB
  } state_e;

  typedef enum logic [2:0] {
    IC_R, IC_I, IC_LOAD, IC_STORE, IC_ILLEGAL
  } iclass_e;
endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and its neighbours: instruction fetch
// handshake plus the datapath control lines.
//   master: control unit (drives fetch request and controls, receives imem data)
//   slave : imem / datapath side
interface control_unit_if #(parameter int WORDSIZE = 64);
  logic [WORDSIZE-1:0] imem_addr;
  logic                imem_req;
  logic                imem_ready;
  logic [31:0]         imem_data;
  logic [4:0]          rf_addr_a;
  logic [4:0]          rf_addr_b;
  logic [4:0]          rf_write_addr;
  logic                rf_write_en;
  logic [11:0]         immediate;
  logic                mux_0_sel;
  logic                mux_1_sel;
  logic                mux_2_sel;
  logic [2:0]          alu_operation;
  logic                dm_write_en;
  logic                illegal_instr;

  modport master (
    output imem_addr, imem_req, rf_addr_a, rf_addr_b, rf_write_addr,
           rf_write_en, immediate, mux_0_sel, mux_1_sel, mux_2_sel,
           alu_operation, dm_write_en, illegal_instr,
    input  imem_ready, imem_data
  );

  modport slave (
    input  imem_addr, imem_req, rf_addr_a, rf_addr_b, rf_write_addr,
           rf_write_en, immediate, mux_0_sel, mux_1_sel, mux_2_sel,
           alu_operation, dm_write_en, illegal_instr,
    output imem_ready, imem_data
  );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// Purely combinational instruction decoder.
//   ir        : instruction register
//   iclass    : R / I / LOAD / STORE / ILLEGAL
//   rs1/rs2/rd: raw register fields
//   imm       : 12-bit immediate (I/LOAD form, STORE split form, 0 for R)
//   alu_op    : ALU operation
//   mux_0_sel : ALU B from immediate; mux_1_sel: writeback from data memory
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_e     iclass,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] imm,
  output alu_op_e     alu_op,
  output logic        mux_0_sel,
  output logic        mux_1_sel
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  always_comb begin
    iclass    = IC_ILLEGAL;
    imm       = '0;
    alu_op    = ALU_ADD;
    mux_0_sel = 1'b0;
    mux_1_sel = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = IC_R;
        case ({f7, f3})
          {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
          {F7_BASE, F3_AND}:     alu_op = ALU_AND;
          {F7_BASE, F3_OR}:      alu_op = ALU_OR;
          {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
          default:               iclass = IC_ILLEGAL;
        endcase
      end
      OP_IMM: if (f3 == F3_ADD_SUB) begin
        iclass    = IC_I;
        imm       = ir[31:20];
        mux_0_sel = 1'b1;
      end
      OP_LOAD: if (f3 == F3_DOUBLE) begin
        iclass    = IC_LOAD;
        imm       = ir[31:20];
        mux_0_sel = 1'b1;
        mux_1_sel = 1'b1;
      end
      OP_STORE: if (f3 == F3_DOUBLE) begin
        iclass    = IC_STORE;
        imm       = {ir[31:25], ir[11:7]};
        mux_0_sel = 1'b1;
      end
      default: iclass = IC_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/control stage. Holds PC and IR, fetches over a
// ready handshake and sequences datapath controls through
// FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch handshake + datapath control lines (master side)
module control_unit
  import cpu_pkg::*;
#(
  parameter int                  WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  control_unit_if.master  bus
);
  localparam logic [WORDSIZE-1:0] PC_STEP = WORDSIZE'(4);

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;

  iclass_e     iclass;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm;
  alu_op_e     alu_op;
  logic        m0, m1;

  instr_decoder u_dec (
    .ir(ir_q), .iclass(iclass), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .mux_0_sel(m0), .mux_1_sel(m1)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: if (bus.imem_ready) begin
        ir_d    = bus.imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (iclass == IC_ILLEGAL) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = (iclass == IC_LOAD || iclass == IC_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        // Stores retire here; loads need WB for the synchronous read data.
        if (iclass == IC_STORE) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs derive only from registered state; rst gates them all so a
  // strobe in flight is dropped in the same cycle reset arrives.
  logic active, fields_on;
  assign active    = !rst;
  assign fields_on = active && (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB);

  assign bus.imem_req      = active && (state_q == S_FETCH);
  assign bus.imem_addr     = active ? pc_q : '0;
  assign bus.rf_addr_a     = fields_on ? rs1 : '0;
  assign bus.rf_addr_b     = fields_on ? rs2 : '0;
  assign bus.rf_write_addr = fields_on ? rd  : '0;
  assign bus.immediate     = fields_on ? imm : '0;
  assign bus.mux_0_sel     = fields_on && m0;
  assign bus.mux_1_sel     = fields_on && m1;
  assign bus.mux_2_sel     = 1'b0;
  assign bus.alu_operation = fields_on ? alu_op : 3'b000;
  assign bus.rf_write_en   = active && (state_q == S_WB) && (rd != 5'd0);
  assign bus.dm_write_en   = active && (state_q == S_MEM) && (iclass == IC_STORE);
  assign bus.illegal_instr = active && (state_q == S_DECODE) && (iclass == IC_ILLEGAL);
endmodule

// File: tb/tb_control_unit.sv
// Directed + random instruction stream against a per-instruction cycle
// model. The generator knows the mnemonic it encodes, so expected controls
// come from the mnemonic, not from re-decoding the bits. RESET_PC sits near
// the top of the address space so PC wrap-around is exercised.
module tb_control_unit;
  localparam int          WS       = 64;
  localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef enum logic [3:0] {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_ADDI, M_LD, M_SD, M_ILL} mnem_t;

  typedef struct {
    bit          legal;
    bit          is_ld;
    bit          is_sd;
    logic [2:0]  op;
    logic [11:0] imm;
    bit          m0;
    bit          m1;
  } exp_t;

  logic clk, rst;
  control_unit_if #(.WORDSIZE(WS)) bus ();
  control_unit #(.WORDSIZE(WS), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string t, input logic req, input logic [63:0] addr,
                           input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                           input logic rwe, input logic [11:0] imm, input logic m0,
                           input logic m1, input logic [2:0] op, input logic dwe, input logic ill);
    chk({t, ".req"},  64'(bus.imem_req),      64'(req));
    chk({t, ".addr"}, bus.imem_addr,          addr);
    chk({t, ".ra"},   64'(bus.rf_addr_a),     64'(ra));
    chk({t, ".rb"},   64'(bus.rf_addr_b),     64'(rb));
    chk({t, ".rw"},   64'(bus.rf_write_addr), 64'(rw));
    chk({t, ".rwe"},  64'(bus.rf_write_en),   64'(rwe));
    chk({t, ".imm"},  64'(bus.immediate),     64'(imm));
    chk({t, ".m0"},   64'(bus.mux_0_sel),     64'(m0));
    chk({t, ".m1"},   64'(bus.mux_1_sel),     64'(m1));
    chk({t, ".m2"},   64'(bus.mux_2_sel),     64'(0));
    chk({t, ".op"},   64'(bus.alu_operation), 64'(op));
    chk({t, ".dwe"},  64'(bus.dm_write_en),   64'(dwe));
    chk({t, ".ill"},  64'(bus.illegal_instr), 64'(ill));
  endtask

  function automatic exp_t model(input mnem_t m, input logic [31:0] ins);
    exp_t e;
    e.legal = (m != M_ILL);
    e.is_ld = (m == M_LD);
    e.is_sd = (m == M_SD);
    e.m0    = (m == M_ADDI || m == M_LD || m == M_SD);
    e.m1    = (m == M_LD);
    case (m)
      M_SUB:   e.op = 3'd1;
      M_AND:   e.op = 3'd2;
      M_OR:    e.op = 3'd3;
      M_XOR:   e.op = 3'd4;
      default: e.op = 3'd0;
    endcase
    if (m == M_ADDI || m == M_LD) e.imm = ins[31:20];
    else if (m == M_SD)           e.imm = {ins[31:25], ins[11:7]};
    else                          e.imm = 12'd0;
    return e;
  endfunction

  function automatic logic [31:0] enc(input mnem_t m);
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] im;
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); im = 12'($urandom);
    case (m)
      M_ADD:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      M_SUB:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      M_AND:  return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      M_OR:   return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      M_XOR:  return {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      M_ADDI: return {im, rs1, 3'b000, rd, 7'b0010011};
      M_LD:   return {im, rs1, 3'b011, rd, 7'b0000011};
      M_SD:   return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'b0100011};
      default: begin
        case ($urandom_range(0, 4))
          0: return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011}; // bad funct7
          1: return {7'b0100000, rs2, rs1, 3'b111, rd, 7'b0110011}; // AND with SUB funct7
          2: return {im, rs1, 3'b001, rd, 7'b0010011};              // shift-immediate
          3: return {im, rs1, 3'b010, rd, 7'b0000011};              // 32-bit load
          default: return 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  task automatic run_instr(input mnem_t m, input logic [31:0] ins, input int wait_n, input bit rst_wb);
    exp_t e;
    logic [4:0] ra, rb, rw;
    e  = model(m, ins);
    ra = ins[19:15];
    rb = ins[24:20];
    rw = ins[11:7];
    for (int i = 0; i <= wait_n; i++) begin
      bus.imem_ready = (i == wait_n);
      bus.imem_data  = (i == wait_n) ? ins : $urandom();
      @(negedge clk);
      chk_cycle("fetch", 1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b0;
    bus.imem_data  = $urandom();
    @(negedge clk);
    chk_cycle("decode", 0, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, !e.legal);
    @(posedge clk); #1;
    if (!e.legal) begin
      pc = pc + 64'd4;
      return;
    end
    @(negedge clk);
    chk_cycle("exec", 0, pc, ra, rb, rw, 0, e.imm, e.m0, e.m1, e.op, 0, 0);
    @(posedge clk); #1;
    if (e.is_ld || e.is_sd) begin
      @(negedge clk);
      chk_cycle("mem", 0, pc, ra, rb, rw, 0, e.imm, e.m0, e.m1, e.op, e.is_sd, 0);
      @(posedge clk); #1;
    end
    if (!e.is_sd) begin
      if (rst_wb) begin
        rst = 1'b1;
        @(negedge clk);
        chk_cycle("wb_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pc  = RESET_PC;
        return;
      end
      @(negedge clk);
      chk_cycle("wb", 0, pc, ra, rb, rw, rw != 5'd0, e.imm, e.m0, e.m1, e.op, 0, 0);
      @(posedge clk); #1;
    end
    pc = pc + 64'd4;
  endtask

  initial begin
    mnem_t       m;
    logic [31:0] ins;
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.imem_data  = 32'h0;
    pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    bus.imem_ready = 1'b1;            // must be ignored while in reset
    bus.imem_data  = 32'h00500093;
    @(negedge clk);
    chk_cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(M_ADDI, 32'h00500093, 0, 0);  // at ...F8
    run_instr(M_ADD,  32'h002081B3, 0, 0);  // at ...FC
    run_instr(M_SUB,  32'h40118233, 0, 0);  // wrapped to 0
    run_instr(M_SD,   32'h0020B423, 0, 0);
    run_instr(M_LD,   32'h0080B283, 0, 0);
    run_instr(M_ADD,  32'h002081B3, 3, 0);  // imem stall
    run_instr(M_ILL,  32'hFFFFFFFF, 0, 0);
    run_instr(M_ADD,  32'h00208033, 0, 0);  // rd = 0
    run_instr(M_ADDI, 32'h00500093, 1, 1);  // reset during WB
    run_instr(M_XOR,  32'h0020C1B3, 0, 0);

    for (int k = 0; k < 60; k++) begin
      m   = mnem_t'(4'($urandom_range(0, 8)));
      ins = enc(m);
      run_instr(m, ins, int'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0) && (m != M_SD) && (m != M_ILL));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle fetch/decode/control stage that sits directly upstream of the cpu datapath (register file, ALU, data memory). It holds the PC, fetches 32-bit instructions over a ready handshake, and decodes them. It then sequences the datapath control inputs (register addresses, immediate, mux selects, ALU operation, write enables) across execute, memory and writeback states. Supported subset: ADD, SUB, AND, OR, XOR, ADDI, LD, SD. Every other encoding is flagged illegal and skipped.

Parameters:
WORDSIZE, 64, datapath word and PC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  WORDSIZE  instruction fetch address (= PC)
imem_req  out  1  fetch request
imem_ready  in  1  imem_data valid this cycle
imem_data  in  32  fetched instruction word
rf_addr_a  out  5  rs1
rf_addr_b  out  5  rs2
rf_write_addr  out  5  rd
rf_write_en  out  1  register file write strobe
immediate  out  12  sign-unextended 12-bit immediate
mux_0_sel  out  1  ALU input B: 0 = rf_data_b, 1 = immediate
mux_1_sel  out  1  rf write data: 0 = alu_result, 1 = dm_data_output
mux_2_sel  out  1  reserved; driven 0
alu_operation  out  3  ALU opcode
dm_write_en  out  1  data memory write strobe
illegal_instr  out  1  one-cycle pulse on unsupported encoding

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB.
- Reset:
  - State = FETCH, PC = RESET_PC, IR = 0.
  - While rst = 1, every output is 0, including imem_req, rf_write_en and dm_write_en, which are gated combinationally by !rst.
  - Reset asserted in any state takes priority: the next state is FETCH with PC = RESET_PC, and any in-flight write strobe is dropped in the same cycle.
- FETCH:
  - imem_req = 1 and imem_addr = PC, both held stable until imem_ready.
  - On a cycle with imem_ready = 1, IR <= imem_data and the next state is DECODE.
  - Minimum one cycle; imem_data is ignored when imem_ready = 0.
- DECODE (1 cycle):
  - Classifies IR.
  - Illegal encoding: illegal_instr = 1 for this cycle, PC <= PC + 4, next state FETCH.
  - Legal encoding: next state EXECUTE.
- Field mapping from IR:
  - rf_addr_a = IR[19:15], rf_addr_b = IR[24:20], rf_write_addr = IR[11:7].
  - immediate = IR[31:20] for I-type and LD; {IR[31:25], IR[11:7]} for SD; 0 for R-type.
  - These outputs are 0 in FETCH and DECODE, and held constant from IR through EXECUTE, MEM and WB.
- Decode classes:
  - R-type: opcode 0110011, funct7 0000000 or 0100000 per op below.
  - ADDI: opcode 0010011, funct3 000.
  - LD: opcode 0000011, funct3 011.
  - SD: opcode 0100011, funct3 011.
- ALU operation codes:
  - ADD 000: funct3 000, funct7 0000000. Also used by ADDI, LD, SD.
  - SUB 001: funct3 000, funct7 0100000.
  - AND 010: funct3 111.
  - OR 011: funct3 110.
  - XOR 100: funct3 100.
- Mux selects:
  - mux_0_sel = 1 for ADDI, LD and SD.
  - mux_1_sel = 1 for LD only.
- Sequences (excluding imem wait):
  - R-type / ADDI: FETCH → DECODE → EXECUTE → WB → FETCH. 4 cycles.
  - LD: FETCH → DECODE → EXECUTE → MEM → WB → FETCH. 5 cycles. MEM allows for the synchronous memory read.
  - SD: FETCH → DECODE → EXECUTE → MEM → FETCH. dm_write_en = 1 for exactly the MEM cycle.
- WB: rf_write_en = 1 for exactly one cycle, suppressed when rd = 0.
- PC update: PC <= PC + 4 on exit from WB, from MEM (SD) or from DECODE (illegal). PC wraps modulo 2^WORDSIZE.
- Write strobes are never asserted outside their designated state. rf_write_en and dm_write_en are never asserted in the same cycle.

Decomposition:
- Package cpu_pkg:
  - Opcode, funct3 and funct7 localparams.
  - ALU operation codes (shared with the alu).
  - State encoding.
  - Instruction-class enum (R, I, LOAD, STORE, ILLEGAL).
- Sub-module instr_decoder: purely combinational.
  - Input: IR.
  - Outputs: class, rs1, rs2, rd, immediate, alu_operation, mux selects.
  - control_unit keeps the FSM, PC and IR.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem_ready immediate → EXECUTE shows alu_operation = 000, mux_0_sel = 1, immediate = 0x005, rf_addr_a = 0. WB: rf_write_en = 1, rf_write_addr = 1. imem_addr = 4 at the next FETCH.
- ADD x3,x1,x2 (0x002081B3) then SUB x4,x3,x1 (0x40118233) → alu_operation 000 then 001, mux_0_sel = 0, rf_addr_b 2 then 1. Each instruction takes exactly 4 cycles.
- SD x2,8(x1) (0x0020B423) → immediate = 0x008, dm_write_en high one MEM cycle, rf_write_en never asserted. LD x5,8(x1) (0x0080B283) → mux_1_sel = 1, WB writes rd = 5, total 5 cycles.
- imem_ready held low 3 cycles → imem_req and imem_addr stable, no state advance. IR is captured only on the ready cycle.
- 0xFFFFFFFF, then ADD with rd = 0 → illegal_instr pulses one cycle in DECODE and PC += 4. For the ADD, rf_write_en stays 0 in WB.
- rst asserted during WB of ADDI → rf_write_en = 0 that cycle. Next cycle: FETCH with imem_addr = RESET_PC.
